// File: rtl/pix_init_gen.sv
// -----------------------------------------------------------------------------
// pix_init_gen
//   Startup-release generator for the bayer2rgb pixel path. It watches the
//   free-running pixel counter. On the first nonzero change it waits a
//   programmable number of mclk cycles, then raises rst_int, which is the
//   downstream "pipeline valid/release" signal.
//   The block also provides:
//     - enable gating,
//     - re-arming when the counter returns to zero,
//     - a stall watchdog that drops rst_int when the pixel stream stops.
//
// Ports
//   mclk       in   pixel clock
//   rst        in   asynchronous, active-high reset
//   en         in   block enable; low forces IDLE and clears counters/stall
//   pixcnt     in   pixel counter from the sensor timing block
//   delay_cfg  in   release delay, latched on entry to DELAY
//   rst_int    out  release: high while the downstream pipeline runs
//   done_pulse out  one-cycle pulse on the cycle rst_int first rises
//   stall      out  sticky stall flag (cleared by restart or !en)
//   state_o    out  current state: 0 IDLE, 1 DELAY, 2 RUN, 3 STALL
// -----------------------------------------------------------------------------
module pix_init_gen #(
   parameter int CNT_W       = 12,
   parameter int DLY_W       = 10,
   parameter int STALL_W     = 16,
   parameter int STALL_LIMIT = 4095,
   parameter int REARM_ZERO  = 1
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] pixcnt,
   input  logic [DLY_W-1:0] delay_cfg,
   output logic             rst_int,
   output logic             done_pulse,
   output logic             stall,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RUN   = 2'd2,
      S_STALL = 2'd3
   } state_t;

   localparam bit               STALL_EN = (STALL_LIMIT != 0);
   localparam bit               REARM_EN = (REARM_ZERO != 0);
   // Compare against LIMIT-1 on the current count, so the stall edge is the
   // STALL_LIMIT-th idle edge after RUN entry or after the last change.
   localparam logic [STALL_W-1:0] LIMIT_M1 = STALL_W'(STALL_LIMIT - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   pixcnt_q;
   logic [DLY_W-1:0]   dly_cnt, dly_cnt_n;
   logic [DLY_W-1:0]   dly_lat, dly_lat_n;
   logic [STALL_W-1:0] idle_cnt, idle_cnt_n;
   logic               rst_int_n, done_n, stall_n;
   logic               pix_chg, pix_nz;

   // Idle counter saturates instead of wrapping.
   // This means a watchdog with a long limit can never false-fire after a wrap.
   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign pix_chg = (pixcnt != pixcnt_q);
   assign pix_nz  = (pixcnt != '0);
   assign state_o = state;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         pixcnt_q   <= '0;
         dly_cnt    <= '0;
         dly_lat    <= '0;
         idle_cnt   <= '0;
         rst_int    <= 1'b0;
         done_pulse <= 1'b0;
         stall      <= 1'b0;
      end else begin
         state      <= state_n;
         pixcnt_q   <= pixcnt;
         dly_cnt    <= dly_cnt_n;
         dly_lat    <= dly_lat_n;
         idle_cnt   <= idle_cnt_n;
         rst_int    <= rst_int_n;
         done_pulse <= done_n;
         stall      <= stall_n;
      end
   end

   always_comb begin
      state_n    = state;
      dly_cnt_n  = dly_cnt;
      dly_lat_n  = dly_lat;
      idle_cnt_n = idle_cnt;
      rst_int_n  = 1'b0;
      done_n     = 1'b0;
      stall_n    = stall;

      if (!en) begin
         state_n    = S_IDLE;
         dly_cnt_n  = '0;
         dly_lat_n  = '0;
         idle_cnt_n = '0;
         stall_n    = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pix_chg && pix_nz) begin
                  state_n   = S_DELAY;
                  dly_cnt_n = '0;
                  dly_lat_n = delay_cfg;
               end
            end
            S_DELAY: begin
               // delay_cfg was latched on entry, so later changes to it are ignored here.
               if (dly_cnt == dly_lat) begin
                  state_n    = S_RUN;
                  rst_int_n  = 1'b1;
                  done_n     = 1'b1;
                  idle_cnt_n = '0;
               end else begin
                  dly_cnt_n = dly_cnt + 1'b1;
               end
            end
            S_RUN: begin
               rst_int_n  = 1'b1;
               idle_cnt_n = pix_chg ? '0 : sat_inc(idle_cnt);
               if (REARM_EN && pix_chg && !pix_nz) begin
                  state_n   = S_IDLE;
                  rst_int_n = 1'b0;
               end else if (STALL_EN && !pix_chg && idle_cnt == LIMIT_M1) begin
                  state_n   = S_STALL;
                  rst_int_n = 1'b0;
                  stall_n   = 1'b1;
               end
            end
            S_STALL: begin
               stall_n = 1'b1;
               if (pix_chg && pix_nz) begin
                  state_n   = S_DELAY;
                  dly_cnt_n = '0;
                  dly_lat_n = delay_cfg;
                  stall_n   = 1'b0;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule
